// File: rtl/sphere_hit_sequencer.sv
// Walks a ray through every entry of the sphere table and reports the nearest
// valid hit. One table read (FETCH) and one detector evaluation (TEST) per entry.
module sphere_hit_sequencer #(
    parameter int          NUM_SPHERES = 4,
    parameter int          IDX_W       = 2,
    parameter logic [63:0] TMAX        = 64'h7FFF_FFFF_FFFF_FFFF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [191:0]     in_ray,
    output logic [IDX_W-1:0] sphere_addr,
    input  logic [191:0]     sphere_rdata,
    output logic [191:0]     det_sphere,
    output logic [191:0]     det_ray,
    output logic [63:0]      det_tbest,
    input  logic [63:0]      det_tnew,
    input  logic             det_collision,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [63:0]      out_t,
    output logic [IDX_W-1:0] out_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        TEST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPHERES - 1);

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] best_idx_r;
    logic [63:0]      best_t_r;
    logic             hit_r;
    logic [191:0]     ray_r;

    logic             accept_s;
    logic [63:0]      final_t_s;
    logic [IDX_W-1:0] final_idx_s;

    // Strictly closer positive hits only; a tie keeps the earlier (lower) index.
    assign accept_s    = det_collision
                         && ($signed(det_tnew) > 64'sd0)
                         && ($signed(det_tnew) < $signed(best_t_r));
    assign final_t_s   = accept_s ? det_tnew : best_t_r;
    assign final_idx_s = accept_s ? idx_r : best_idx_r;

    assign det_sphere = sphere_rdata;
    assign det_ray    = ray_r;
    assign det_tbest  = best_t_r;

    // Sequencer FSM with all handshake and result outputs registered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            best_idx_r  <= '0;
            best_t_r    <= TMAX;
            hit_r       <= 1'b0;
            ray_r       <= 192'd0;
            in_ready    <= 1'b1;
            sphere_addr <= '0;
            out_valid   <= 1'b0;
            out_hit     <= 1'b0;
            out_t       <= TMAX;
            out_index   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        ray_r       <= in_ray;
                        best_t_r    <= TMAX;
                        best_idx_r  <= '0;
                        hit_r       <= 1'b0;
                        idx_r       <= '0;
                        sphere_addr <= '0;
                        in_ready    <= 1'b0;
                        state_r     <= FETCH;
                    end
                end
                FETCH: begin
                    state_r <= TEST;
                end
                TEST: begin
                    if (accept_s) begin
                        best_t_r   <= det_tnew;
                        best_idx_r <= idx_r;
                        hit_r      <= 1'b1;
                    end
                    // The result registers take the post-acceptance view directly.
                    if (idx_r == LAST_IDX) begin
                        sphere_addr <= '0;
                        out_valid   <= 1'b1;
                        out_hit     <= hit_r | accept_s;
                        out_t       <= final_t_s;
                        out_index   <= final_idx_s;
                        state_r     <= DONE;
                    end else begin
                        idx_r       <= idx_r + IDX_W'(1);
                        sphere_addr <= idx_r + IDX_W'(1);
                        state_r     <= FETCH;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready    <= 1'b1;
                    out_valid   <= 1'b0;
                    sphere_addr <= '0;
                end
            endcase
        end
    end

endmodule
